mem_access_arbiter: RTL and testbench
=====================================

# mem_access_arbiter

Two-requester, round-robin arbiter and sequencer for a single-port 64-entry memory. Each requester presents an address, write flag and write data over a valid/ready handshake. The block serialises accepted requests onto the memory `en`/`wr`/`addr`/`wdata` port on `clk` (25 MHz system clock, 40 ns period). It returns a one-cycle response pulse carrying read data, or zero for writes, to the requester that owns the transaction.

## Interface
- `DW`, 8, data width
- `AW`, 6, address width (64 locations)
- `MEM_LAT`, 1, memory read latency in cycles; legal range 1..4
- `clk` in 1: system clock, all logic on posedge
- `rst` in 1: synchronous, active-high reset
- `req0_valid` / `req1_valid` in 1: request pending
- `req0_ready` / `req1_ready` out 1: request accepted this cycle when valid & ready
- `req0_addr` / `req1_addr` in AW: target address
- `req0_wr` / `req1_wr` in 1: 1 = write, 0 = read
- `req0_wdata` / `req1_wdata` in DW: write data
- `rsp0_valid` / `rsp1_valid` out 1: one-cycle completion pulse to the owner
- `rsp0_rdata` / `rsp1_rdata` out DW: response data; both driven from one shared register
- `mem_en` out 1: memory enable
- `mem_wr` out 1: memory write strobe
- `mem_addr` out AW: memory address
- `mem_wdata` out DW: memory write data
- `mem_rdata` in DW: memory read data, valid `MEM_LAT` cycles after the `mem_en` cycle
- `busy` out 1: high whenever the state is not IDLE

## Operation
- States:
  - IDLE → ISSUE on handshake.
  - ISSUE → WAIT on a read, or → RESP on a write.
  - WAIT holds for `MEM_LAT` cycles, then → RESP.
  - RESP → IDLE.
- Grant and ready (IDLE only):
  - `req0_ready = IDLE & !rst & (!req1_valid | prio==0)`.
  - `req1_ready = IDLE & !rst & (!req0_valid | prio==1)`.
  - With no valids, both readies are 1.
- Handshake capture: on the handshake edge, register `addr`/`wr`/`wdata` and `owner`, and set `prio` to the non-granted index.
- ISSUE: `mem_en=1`, with `mem_wr`, `mem_addr` and `mem_wdata` taken from the captured registers. Outside ISSUE, all `mem_*` outputs are 0.
- WAIT: a down-counter loaded with `MEM_LAT`. `mem_rdata` is captured into the response register on the edge ending the last WAIT cycle.
- Write completion: the response register is loaded with 0 on the edge ending ISSUE.
- RESP: `rsp<owner>_valid=1`; the other requester's `rsp_valid` stays 0.
- Response data: `rsp_rdata` holds its value until the next load.
- Only one transaction is in flight. No request is accepted outside IDLE; `valid` must be held until `ready`.
- Reset: state, `prio` and `owner` go to IDLE / 0 / 0, and all captured registers clear.
  - Reset mid-transaction drops it: no `rsp_valid` and no further `mem_en`.
- Width rules:
  - Addresses are unsigned 0..63 with no translation.
  - `wdata` and `rdata` pass through unmodified.

## Timing
- Reset values: every registered output is 0 while `rst` is high and on the first cycle after release.
  - This covers `mem_en`, `mem_wr`, `mem_addr`, `mem_wdata`, `rsp*_valid`, `rsp*_rdata` and `busy`.
  - `req*_ready` are 0 while `rst` is high.
- Write accepted at cycle T:
  - T+1: ISSUE, `mem_en=1`, `mem_wr=1`.
  - T+2: RESP, `rsp_valid=1`, `rdata=0`.
  - T+3: IDLE, ready again.
- Read accepted at cycle T:
  - T+1: ISSUE, `mem_en=1`, `mem_wr=0`.
  - T+2 … T+1+MEM_LAT: WAIT.
  - T+2+MEM_LAT: RESP.
  - T+3+MEM_LAT: IDLE.
- Throughput: the best case is one write every 3 cycles and one read every 3+`MEM_LAT` cycles.
- Simultaneous valids: the grant goes to `prio`, and priority alternates on every grant. With both requesters continuously asserting, grants strictly alternate 0, 1, 0, 1.
- A single valid requester is granted regardless of `prio`. `prio` still flips to the other index.
- A `valid` that drops before `ready` is not recorded.
- `busy` rises the cycle after the handshake and falls in the IDLE cycle following RESP.

## Test plan
- Reset: hold `rst` for 2 cycles with both valids high → all outputs 0 and readies 0 during reset. First grant after release goes to req0.
- Single write then read, `MEM_LAT=1`: req0 writes `addr=6'h2A`, `wdata=8'hC3`.
  - Expect `mem_en`/`mem_wr` at T+1 with `mem_addr=6'h2A`, and `rsp0_valid` at T+2 with `rdata=0`.
  - Read back at `6'h2A` → `rsp0_valid` at T+3 with `rdata=8'hC3`; `rsp1_valid` stays 0 throughout.
- Contention: both requesters issue back-to-back reads of `6'h00` and `6'h3F` for 4 transactions each → grant order 0, 1, 0, 1, 0, 1, 0, 1. Each `rsp` pulse goes only to its owner, with correct data.
- Latency sweep: `MEM_LAT=3`, read at `6'h3F` → `rsp_valid` exactly 5 cycles after the handshake; `busy` is high for 5 cycles.
- Reset mid-read: assert `rst` during WAIT → no `rsp*_valid` pulse, IDLE the cycle after `rst` falls, and a pending `req1` is granted next.
- Held valid: `req1_valid` is high while a `req0` transaction runs → `req1_ready` stays 0 until IDLE and is accepted in the first IDLE cycle.

Source files
------------

// File: rtl/mem_access_arbiter_if.sv
// mem_access_arbiter_if: request, response and memory bus of the two-requester arbiter
// Signals:
//   req0_*/req1_*  valid/ready request handshake with addr, wr flag and write data
//   rsp0_*/rsp1_*  one-cycle completion pulse and shared response data
//   mem_*          single-port memory enable/write/address/data and read data return
// Modports:
//   slave  - arbiter view (takes requests, drives responses and the memory port)
//   master - environment view (requesters and memory)
interface mem_access_arbiter_if #(
    parameter int DW = 8,
    parameter int AW = 6
);
    logic          req0_valid;
    logic          req0_ready;
    logic          req0_wr;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          req1_valid;
    logic          req1_ready;
    logic          req1_wr;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          rsp0_valid;
    logic [DW-1:0] rsp0_rdata;
    logic          rsp1_valid;
    logic [DW-1:0] rsp1_rdata;
    logic          mem_en;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  req0_valid, req0_wr, req0_addr, req0_wdata,
        input  req1_valid, req1_wr, req1_addr, req1_wdata,
        input  mem_rdata,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
        output mem_en, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output req0_valid, req0_wr, req0_addr, req0_wdata,
        output req1_valid, req1_wr, req1_addr, req1_wdata,
        output mem_rdata,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
        input  mem_en, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: round-robin arbiter and sequencer for a single-port memory
// Ports:
//   clk   system clock, all logic on posedge
//   rst   synchronous active-high reset
//   bus   request/response/memory bus (slave view)
//   busy  high whenever a transaction is in flight
module mem_access_arbiter #(
    parameter int DW      = 8,
    parameter int AW      = 6,
    parameter int MEM_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_access_arbiter_if.slave   bus,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic          prio_q, prio_d;
    logic          owner_q, owner_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          live, idle, issue, hs0, hs1;

    // Outputs are masked while rst is high so nothing leaks during reset.
    assign live  = !rst;
    assign idle  = state_q == IDLE;
    assign issue = live && state_q == ISSUE;

    assign bus.req0_ready = live && idle && (!bus.req1_valid || !prio_q);
    assign bus.req1_ready = live && idle && (!bus.req0_valid || prio_q);
    assign hs0 = bus.req0_valid && bus.req0_ready;
    assign hs1 = bus.req1_valid && bus.req1_ready;

    assign bus.mem_en     = issue;
    assign bus.mem_wr     = issue && wr_q;
    assign bus.mem_addr   = issue ? addr_q : '0;
    assign bus.mem_wdata  = issue ? wdata_q : '0;
    assign bus.rsp0_valid = live && state_q == RESP && !owner_q;
    assign bus.rsp1_valid = live && state_q == RESP && owner_q;
    assign bus.rsp0_rdata = live ? rdata_q : '0;
    assign bus.rsp1_rdata = live ? rdata_q : '0;
    assign busy           = live && !idle;

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        owner_d = owner_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (hs0 || hs1) begin
                state_d = ISSUE;
                owner_d = hs1;
                prio_d  = !hs1;
                wr_d    = hs1 ? bus.req1_wr : bus.req0_wr;
                addr_d  = hs1 ? bus.req1_addr : bus.req0_addr;
                wdata_d = hs1 ? bus.req1_wdata : bus.req0_wdata;
            end
            ISSUE: begin
                state_d = wr_q ? RESP : WAIT;
                rdata_d = wr_q ? '0 : rdata_q;
                cnt_d   = 3'(MEM_LAT);
            end
            WAIT: begin
                // Read data is valid during the last WAIT cycle.
                cnt_d   = cnt_q - 3'd1;
                state_d = cnt_q == 3'd1 ? RESP : WAIT;
                rdata_d = cnt_q == 3'd1 ? bus.mem_rdata : rdata_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            owner_q <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb_mem_access_arbiter: model-checked directed bench for two arbiter instances (MEM_LAT 1 and 3)
module tb_mem_access_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #20 clk = ~clk;

    int sel = 0;
    int cyc = 0;
    int total = 0;
    int passed = 0;
    int busy_cnt = 0;
    logic v0 = 1'b0, v1 = 1'b0, w0 = 1'b0, w1 = 1'b0;
    logic [5:0] a0 = '0, a1 = '0;
    logic [7:0] d0 = '0, d1 = '0;

    mem_access_arbiter_if #(.DW(8), .AW(6)) bus1();
    mem_access_arbiter_if #(.DW(8), .AW(6)) bus3();
    logic busy1, busy3;

    mem_access_arbiter #(.DW(8), .AW(6), .MEM_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1), .busy(busy1));
    mem_access_arbiter #(.DW(8), .AW(6), .MEM_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3), .busy(busy3));

    logic i_v0[2], i_v1[2], i_w0[2], i_w1[2];
    logic [5:0] i_a0[2], i_a1[2];
    logic [7:0] i_d0[2], i_d1[2];
    logic o_r0[2], o_r1[2], o_v0[2], o_v1[2], o_en[2], o_wr[2], o_busy[2];
    logic [5:0] o_addr[2];
    logic [7:0] o_wd[2], o_d0[2], o_d1[2];
    logic [7:0] mem[2][64];
    logic [7:0] pipe[2][4];

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            i_v0[k] = sel == k && v0;
            i_v1[k] = sel == k && v1;
            i_w0[k] = w0;
            i_w1[k] = w1;
            i_a0[k] = a0;
            i_a1[k] = a1;
            i_d0[k] = d0;
            i_d1[k] = d1;
        end
    end

    assign bus1.req0_valid = i_v0[0];
    assign bus1.req1_valid = i_v1[0];
    assign bus1.req0_wr    = i_w0[0];
    assign bus1.req1_wr    = i_w1[0];
    assign bus1.req0_addr  = i_a0[0];
    assign bus1.req1_addr  = i_a1[0];
    assign bus1.req0_wdata = i_d0[0];
    assign bus1.req1_wdata = i_d1[0];
    assign bus1.mem_rdata  = pipe[0][0];
    assign bus3.req0_valid = i_v0[1];
    assign bus3.req1_valid = i_v1[1];
    assign bus3.req0_wr    = i_w0[1];
    assign bus3.req1_wr    = i_w1[1];
    assign bus3.req0_addr  = i_a0[1];
    assign bus3.req1_addr  = i_a1[1];
    assign bus3.req0_wdata = i_d0[1];
    assign bus3.req1_wdata = i_d1[1];
    assign bus3.mem_rdata  = pipe[1][2];

    assign o_r0[0] = bus1.req0_ready;  assign o_r0[1] = bus3.req0_ready;
    assign o_r1[0] = bus1.req1_ready;  assign o_r1[1] = bus3.req1_ready;
    assign o_v0[0] = bus1.rsp0_valid;  assign o_v0[1] = bus3.rsp0_valid;
    assign o_v1[0] = bus1.rsp1_valid;  assign o_v1[1] = bus3.rsp1_valid;
    assign o_d0[0] = bus1.rsp0_rdata;  assign o_d0[1] = bus3.rsp0_rdata;
    assign o_d1[0] = bus1.rsp1_rdata;  assign o_d1[1] = bus3.rsp1_rdata;
    assign o_en[0] = bus1.mem_en;      assign o_en[1] = bus3.mem_en;
    assign o_wr[0] = bus1.mem_wr;      assign o_wr[1] = bus3.mem_wr;
    assign o_addr[0] = bus1.mem_addr;  assign o_addr[1] = bus3.mem_addr;
    assign o_wd[0] = bus1.mem_wdata;   assign o_wd[1] = bus3.mem_wdata;
    assign o_busy[0] = busy1;          assign o_busy[1] = busy3;

    // Memory environment: MEM_LAT-deep read pipe, poison when no read is in it.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (cyc == 0) begin
                for (int i = 0; i < 64; i++) mem[k][i] <= 8'(i * 7 + 3);
            end else if (o_en[k] && o_wr[k]) begin
                mem[k][o_addr[k]] <= o_wd[k];
            end
            pipe[k][0] <= (o_en[k] && !o_wr[k]) ? mem[k][o_addr[k]] : 8'hEE;
            for (int j = 1; j < 4; j++) pipe[k][j] <= pipe[k][j-1];
        end
    end

    // Transaction-level model: a grant at cycle T books the port until T+3(+lat).
    int free_at[2], en_at[2], rsp_at[2];
    logic prio_m[2], own_m[2], t_wr[2];
    logic [5:0] t_addr[2];
    logic [7:0] t_wd[2], rsp_data[2], last_rd[2];
    logic [7:0] refm[2][64];

    function automatic int lat(int k);
        return k == 1 ? 3 : 1;
    endfunction

    function automatic bit m_rdy(int k, int r);
        return cyc >= free_at[k] && (r == 0 ? (!i_v1[k] || !prio_m[k]) : (!i_v0[k] || prio_m[k]));
    endfunction

    function automatic bit m_hs(int k, int r);
        return (r == 0 ? i_v0[k] : i_v1[k]) && m_rdy(k, r);
    endfunction

    function automatic int m_len(int k);
        return (m_hs(k, 1) ? i_w1[k] : i_w0[k]) ? 0 : lat(k);
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 2; k++) begin
            if (cyc == 0) for (int i = 0; i < 64; i++) refm[k][i] <= 8'(i * 7 + 3);
            if (rst) begin
                free_at[k]  <= 0;
                en_at[k]    <= -1;
                rsp_at[k]   <= -1;
                prio_m[k]   <= 1'b0;
                own_m[k]    <= 1'b0;
                t_wr[k]     <= 1'b0;
                last_rd[k]  <= '0;
                rsp_data[k] <= '0;
            end else begin
                if (cyc == en_at[k] && t_wr[k]) refm[k][t_addr[k]] <= t_wd[k];
                if (cyc == en_at[k] && !t_wr[k]) rsp_data[k] <= refm[k][t_addr[k]];
                if (cyc + 1 == rsp_at[k]) last_rd[k] <= rsp_data[k];
                if (m_hs(k, 0) || m_hs(k, 1)) begin
                    own_m[k]   <= m_hs(k, 1);
                    prio_m[k]  <= !m_hs(k, 1);
                    t_wr[k]    <= m_hs(k, 1) ? i_w1[k] : i_w0[k];
                    t_addr[k]  <= m_hs(k, 1) ? i_a1[k] : i_a0[k];
                    t_wd[k]    <= m_hs(k, 1) ? i_d1[k] : i_d0[k];
                    en_at[k]   <= cyc + 1;
                    rsp_at[k]  <= cyc + 2 + m_len(k);
                    free_at[k] <= cyc + 3 + m_len(k);
                    if (m_len(k) == 0) rsp_data[k] <= '0;
                end
            end
        end
    end

    task automatic chk(string n, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (cyc >= 1) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("ready0[%0d]", k), o_r0[k], !rst && m_rdy(k, 0));
                chk($sformatf("ready1[%0d]", k), o_r1[k], !rst && m_rdy(k, 1));
                chk($sformatf("mem_en[%0d]", k), o_en[k], !rst && cyc == en_at[k]);
                chk($sformatf("mem_wr[%0d]", k), o_wr[k], !rst && cyc == en_at[k] && t_wr[k]);
                chk($sformatf("mem_addr[%0d]", k), o_addr[k], (!rst && cyc == en_at[k]) ? t_addr[k] : 0);
                chk($sformatf("mem_wdata[%0d]", k), o_wd[k], (!rst && cyc == en_at[k]) ? t_wd[k] : 0);
                chk($sformatf("rsp0_valid[%0d]", k), o_v0[k], !rst && cyc == rsp_at[k] && !own_m[k]);
                chk($sformatf("rsp1_valid[%0d]", k), o_v1[k], !rst && cyc == rsp_at[k] && own_m[k]);
                chk($sformatf("rsp0_rdata[%0d]", k), o_d0[k], rst ? 0 : last_rd[k]);
                chk($sformatf("rsp1_rdata[%0d]", k), o_d1[k], rst ? 0 : last_rd[k]);
                chk($sformatf("busy[%0d]", k), o_busy[k], !rst && cyc < free_at[k]);
            end
        end
    end

    int glog[$], rlog_own[$], rlog_cyc[$], elog_cyc[$], elog_addr[$], elog_wr[$];
    logic [7:0] rlog_dat[$];

    always @(negedge clk) begin
        if (cyc >= 1) begin
            if (i_v0[sel] && o_r0[sel]) glog.push_back(0);
            if (i_v1[sel] && o_r1[sel]) glog.push_back(1);
            if (o_v0[sel]) begin rlog_own.push_back(0); rlog_cyc.push_back(cyc); rlog_dat.push_back(o_d0[sel]); end
            if (o_v1[sel]) begin rlog_own.push_back(1); rlog_cyc.push_back(cyc); rlog_dat.push_back(o_d1[sel]); end
            if (o_en[sel]) begin elog_cyc.push_back(cyc); elog_addr.push_back(o_addr[sel]); elog_wr.push_back(o_wr[sel]); end
            if (o_busy[sel]) busy_cnt++;
        end
    end

    task automatic clear_logs();
        glog.delete(); rlog_own.delete(); rlog_cyc.delete(); rlog_dat.delete();
        elog_cyc.delete(); elog_addr.delete(); elog_wr.delete();
    endtask

    task automatic drive(int r, bit w, logic [5:0] a, logic [7:0] d);
        if (r == 0) begin v0 = 1'b1; w0 = w; a0 = a; d0 = d; end
        else begin v1 = 1'b1; w1 = w; a1 = a; d1 = d; end
    endtask

    task automatic drop(int r);
        if (r == 0) v0 = 1'b0;
        else v1 = 1'b0;
    endtask

    task automatic wait_grant(int r, output int t);
        bit ok = 1'b0;
        t = -1;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (r == 0 ? o_r0[sel] : o_r1[sel]) begin ok = 1'b1; t = cyc; end
        end
        if (!ok) chk("grant_timeout", 0, 1);
    endtask

    initial begin
        #(40 * 20000);
        $display("FAIL watchdog: bench did not finish");
        $fatal;
    end

    initial begin
        int t, t1, g0, g1, n1;
        v0 = 1'b1; v1 = 1'b1; a0 = 6'h00; a1 = 6'h3F;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        g0 = 0; g1 = 0;
        for (int n = 0; n < 300 && !(g0 == 4 && g1 == 4); n++) begin
            @(negedge clk);
            if (v0 && o_r0[sel]) g0++;
            if (v1 && o_r1[sel]) g1++;
            @(posedge clk); #1;
            if (g0 == 4) v0 = 1'b0;
            if (g1 == 4) v1 = 1'b0;
        end
        chk("contention_grants", g0 + g1, 8);
        repeat (6) @(posedge clk); #1;
        chk("grant_count", glog.size(), 8);
        for (int i = 0; i < 8; i++) chk($sformatf("grant_order[%0d]", i), glog[i], i % 2);
        chk("contention_rsp_count", rlog_own.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("contention_owner[%0d]", i), rlog_own[i], i % 2);
            chk($sformatf("contention_data[%0d]", i), rlog_dat[i], (i % 2) ? 8'hBC : 8'h03);
        end

        clear_logs();
        drive(0, 1'b1, 6'h2A, 8'hC3);
        wait_grant(0, t);
        @(posedge clk); #1 drop(0);
        repeat (4) @(posedge clk); #1;
        chk("wr_en_count", elog_cyc.size(), 1);
        chk("wr_en_cycle", elog_cyc[0] - t, 1);
        chk("wr_en_addr", elog_addr[0], 6'h2A);
        chk("wr_en_wr", elog_wr[0], 1);
        chk("wr_rsp_count", rlog_own.size(), 1);
        chk("wr_rsp_cycle", rlog_cyc[0] - t, 2);
        chk("wr_rsp_data", rlog_dat[0], 0);
        chk("wr_rsp_owner", rlog_own[0], 0);
        drive(0, 1'b0, 6'h2A, 8'h00);
        wait_grant(0, t);
        @(posedge clk); #1 drop(0);
        repeat (6) @(posedge clk); #1;
        chk("rd_rsp_count", rlog_own.size(), 2);
        chk("rd_rsp_cycle", rlog_cyc[1] - t, 3);
        chk("rd_rsp_data", rlog_dat[1], 8'hC3);
        n1 = 0;
        foreach (rlog_own[i]) n1 += rlog_own[i];
        chk("rsp1_never", n1, 0);

        clear_logs();
        drive(0, 1'b1, 6'h05, 8'h5A);
        wait_grant(0, t);
        @(posedge clk); #1 drop(0);
        drive(1, 1'b0, 6'h2A, 8'h00);
        wait_grant(1, t1);
        @(posedge clk); #1 drop(1);
        repeat (6) @(posedge clk); #1;
        chk("held_grant_cycle", t1 - t, 3);
        chk("held_rsp_count", rlog_own.size(), 2);
        chk("held_rsp_owner", rlog_own[1], 1);
        chk("held_rsp_data", rlog_dat[1], 8'hC3);
        chk("held_rsp_cycle", rlog_cyc[1] - t1, 3);

        sel = 1;
        clear_logs();
        busy_cnt = 0;
        drive(0, 1'b0, 6'h3F, 8'h00);
        wait_grant(0, t);
        @(posedge clk); #1 drop(0);
        repeat (8) @(posedge clk); #1;
        chk("lat3_rsp_cycle", rlog_cyc[0] - t, 5);
        chk("lat3_rsp_data", rlog_dat[0], 8'hBC);
        chk("lat3_busy_cycles", busy_cnt, 5);

        clear_logs();
        drive(0, 1'b0, 6'h3F, 8'h00);
        wait_grant(0, t);
        @(posedge clk); #1 drop(0);
        drive(1, 1'b1, 6'h11, 8'h77);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        wait_grant(1, t1);
        @(posedge clk); #1 drop(1);
        repeat (6) @(posedge clk); #1;
        chk("midrst_grant_cycle", t1 - t, 3);
        chk("midrst_rsp_count", rlog_own.size(), 1);
        chk("midrst_rsp_owner", rlog_own[0], 1);
        chk("midrst_rsp_data", rlog_dat[0], 0);
        chk("midrst_rsp_cycle", rlog_cyc[0] - t1, 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
